dvvm_dot_sequencer: RTL and testbench
=====================================

Name: dvvm_dot_sequencer

Overview:
Initiator side of the MAC enable/A/B/result/done interface: holds two operand vectors and walks them element by element through one MAC_pipelined instance (external). Each returned product is summed into a dot-product accumulator; a one-cycle done pulse marks the end of the run. Sits between the host load path and the MAC in the dense vector-vector multiplier.

Parameters:
DATA_W, 8, operand element width (matches MAC A/B)
DEPTH, 16, max vector length (elements per buffer)
ADDR_W, 4, clog2(DEPTH)
PROD_W, 16, MAC result width (2*DATA_W)
ACC_W, 20, accumulator width (PROD_W + ADDR_W, no overflow possible)
TIMEOUT_CYC, 64, watchdog limit (only with DVVM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe
wr_sel  in  1  0 = vector A, 1 = vector B
wr_addr  in  ADDR_W  element index
wr_data  in  DATA_W  element value
start  in  1  begin a dot product (sampled in IDLE only)
len  in  ADDR_W+1  element count, 0..DEPTH
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse
dot_result  out  ACC_W  sum of A[i]*B[i], i < len
mac_enable  out  1  one-cycle issue strobe to MAC
mac_a  out  DATA_W  operand A to MAC
mac_b  out  DATA_W  operand B to MAC
mac_result  in  PROD_W  MAC product
mac_done  in  1  MAC completion (pulse or level)

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, mac_enable = 0; mac_a, mac_b, dot_result, acc, idx = 0; done-edge register = 0; buffer contents not reset.
- Writes: wr_en in IDLE writes the selected buffer at wr_addr on the clock edge. Writes while busy=1 are dropped. wr_addr >= DEPTH is dropped.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE: start=1 latches len, clamped to DEPTH when len > DEPTH; acc=0; idx=0. If len = 0, next state FINISH; otherwise ISSUE. start while not IDLE is ignored.
- ISSUE (1 cycle): mac_enable=1; mac_a=A[idx], mac_b=B[idx]. mac_a and mac_b stay stable until the next ISSUE. Next state WAIT.
- WAIT: a completion is the rising edge of mac_done (mac_done=1 and mac_done_q=0). This accepts both pulse and level-held done. The MAC latency is >= 2 cycles from enable; earlier edges are not possible.
  - On a completion: acc += zero-extended mac_result.
  - If idx = len-1, next state FINISH; otherwise idx++ and next state ISSUE.
- FINISH (1 cycle): done=1; dot_result=acc, held until the next FINISH; next state IDLE. busy=0 once back in IDLE.
- Throughput: one element per (MAC latency + 2) cycles. There is no overlap of issues.
- Reset mid-run: the run is aborted immediately and all outputs return to reset values. No done pulse is generated.

Optional Feature:
DVVM_TIMEOUT_EN
- Defined:
  - Adds output err (1 bit, reset 0) and a WAIT cycle counter.
  - If no completion arrives within TIMEOUT_CYC cycles of entering WAIT, go to FINISH with done=1, err=1, and dot_result = partial acc.
  - err clears on the next accepted start.
- Undefined: no counter and no err port; WAIT waits indefinitely.

Decomposition:
- Package dvvm_pkg: DATA_W, PROD_W, DEPTH, ADDR_W, ACC_W constants; FSM state enum (IDLE/ISSUE/WAIT/FINISH); helper function for zero-extension to ACC_W.
- One natural sub-module, dvvm_vec_buf: DEPTH x DATA_W register file with one write port and one async read port, instantiated twice (A and B).
- FSM, accumulator and done-edge detect live in the top.

Test Plan:
- Load A=[1,2,3,4], B=[5,6,7,8], len=4, start; behavioural MAC model with latency 3 -> exactly 4 mac_enable pulses with (1,5),(2,6),(3,7),(4,8); done pulse once; dot_result=70; busy low after done.
- A[0..15]=255, B[0..15]=255, len=16 -> dot_result=1,040,400 (fits 20 bits); no wrap.
- len=0, start -> done 2 cycles after start; dot_result=0; no mac_enable.
- MAC model holds done high as a level between ops; A=[3,15], B=[4,10], len=2 -> each product accepted once; dot_result=162.
- Assert rst_n=0 while in WAIT -> outputs reset asynchronously, no done; then a new run A=[2], B=[9], len=1 -> dot_result=18.
- (DVVM_TIMEOUT_EN) MAC model never asserts done, TIMEOUT_CYC=64 -> done and err=1 after 64 WAIT cycles, dot_result=0; next start clears err.

Source files
------------

// File: rtl/dvvm_pkg.sv
// Shared constants, FSM state encoding and helpers for the dense vector-vector
// dot-product sequencer.
package dvvm_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned PROD_W      = 2 * DATA_W;
  localparam int unsigned ACC_W       = PROD_W + ADDR_W;
  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int unsigned TO_W        = 7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_e;

  function automatic logic [ACC_W-1:0] zext_acc(input logic [PROD_W-1:0] p);
    return {{(ACC_W - PROD_W){1'b0}}, p};
  endfunction

endpackage

// File: rtl/dvvm_dot_sequencer_if.sv
// MAC issue/result channel: the sequencer is the master, the MAC the slave.
interface dvvm_dot_sequencer_if;
  import dvvm_pkg::*;

  logic              mac_enable;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic [PROD_W-1:0] mac_result;
  logic              mac_done;

  modport master (output mac_enable, mac_a, mac_b, input mac_result, mac_done);
  modport slave  (input mac_enable, mac_a, mac_b, output mac_result, mac_done);
endinterface

// File: rtl/dvvm_vec_buf.sv
// DEPTH x DATA_W operand register file: one synchronous write port, one
// combinational read port. Contents are deliberately not reset.
module dvvm_vec_buf
  import dvvm_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/dvvm_dot_sequencer.sv
// Walks two operand buffers through an external MAC one element at a time and
// sums the products. Optional WAIT watchdog with err output: DVVM_TIMEOUT_EN.
module dvvm_dot_sequencer
  import dvvm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                start,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic                done,
  output logic [ACC_W-1:0]    dot_result,
`ifdef DVVM_TIMEOUT_EN
  output logic                err,
`endif
  dvvm_dot_sequencer_if.master mac
);

  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    dot_result_q, dot_result_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mac_enable_q, mac_enable_d;
  logic [DATA_W-1:0]   mac_a_q, mac_a_d;
  logic [DATA_W-1:0]   mac_b_q, mac_b_d;
  logic                mac_done_q;
  logic [DATA_W-1:0]   a_rd, b_rd;
  logic                buf_wr_ok;
  logic                completion;
  logic                last_elem;
`ifdef DVVM_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0]     wcnt_q, wcnt_d;
  logic                err_q, err_d;
`endif

  assign buf_wr_ok = wr_en && (state_q == IDLE);

  dvvm_vec_buf u_buf_a (
    .clk     (clk),
    .wr_en   (buf_wr_ok && !wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_q),
    .rd_data (a_rd)
  );

  dvvm_vec_buf u_buf_b (
    .clk     (clk),
    .wr_en   (buf_wr_ok && wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_q),
    .rd_data (b_rd)
  );

  // Rising-edge detect lets the MAC either pulse done or hold it as a level.
  assign completion = mac.mac_done && !mac_done_q;
  assign last_elem  = (({1'b0, idx_q} + LEN_ONE) == len_q);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    dot_result_d = dot_result_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    mac_enable_d = 1'b0;
    mac_a_d      = mac_a_q;
    mac_b_d      = mac_b_q;
`ifdef DVVM_TIMEOUT_EN
    wcnt_d       = wcnt_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = (len > LEN_MAX) ? LEN_MAX : len;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = (len == '0) ? FINISH : ISSUE;
`ifdef DVVM_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        mac_enable_d = 1'b1;
        mac_a_d      = a_rd;
        mac_b_d      = b_rd;
        state_d      = WAIT;
`ifdef DVVM_TIMEOUT_EN
        wcnt_d       = '0;
`endif
      end
      WAIT: begin
        if (completion) begin
          acc_d = acc_q + zext_acc(mac.mac_result);
          if (last_elem) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ISSUE;
          end
        end
`ifdef DVVM_TIMEOUT_EN
        else if (wcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          wcnt_d = wcnt_q + TO_W'(1);
        end
`endif
      end
      FINISH: begin
        done_d       = 1'b1;
        dot_result_d = acc_q;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      dot_result_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mac_enable_q <= 1'b0;
      mac_a_q      <= '0;
      mac_b_q      <= '0;
      mac_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      dot_result_q <= dot_result_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mac_enable_q <= mac_enable_d;
      mac_a_q      <= mac_a_d;
      mac_b_q      <= mac_b_d;
      mac_done_q   <= mac.mac_done;
    end
  end

`ifdef DVVM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign dot_result     = dot_result_q;
  assign mac.mac_enable = mac_enable_q;
  assign mac.mac_a      = mac_a_q;
  assign mac.mac_b      = mac_b_q;

endmodule

// File: tb/tb_dvvm_dot_sequencer.sv
// Scoreboard bench for dvvm_dot_sequencer with a behavioural latency-3 MAC
// that can pulse done, hold it as a level, or never answer.
module tb_dvvm_dot_sequencer;
  import dvvm_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic              wr_sel = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  dot_result;
`ifdef DVVM_TIMEOUT_EN
  logic              err;
`endif

  dvvm_dot_sequencer_if mif ();

  dvvm_dot_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .dot_result (dot_result),
`ifdef DVVM_TIMEOUT_EN
    .err        (err),
`endif
    .mac        (mif.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0]      exp_pairs [$];
  logic [ACC_W-1:0] exp_res   [$];
  bit               exp_err   [$];

  // 0: pulsed done, 1: level-held done, 2: never completes
  int mac_mode = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural MAC: done appears two edges after the enable is sampled.
  logic [15:0] prod;
  int          cnt;
  bit          pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mif.mac_done   <= 1'b0;
      mif.mac_result <= '0;
      pend           <= 1'b0;
      cnt            <= 0;
      prod           <= '0;
    end else begin
      if (mac_mode == 0) mif.mac_done <= 1'b0;
      if (mif.mac_enable) begin
        pend <= 1'b1;
        cnt  <= 2;
        prod <= 16'(mif.mac_a) * 16'(mif.mac_b);
        if (mac_mode == 1) mif.mac_done <= 1'b0;
      end else if (pend) begin
        if (cnt == 1) begin
          pend <= 1'b0;
          if (mac_mode != 2) begin
            mif.mac_done   <= 1'b1;
            mif.mac_result <= prod;
          end
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues or completes.
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (mif.mac_enable) begin
        if (exp_pairs.size() == 0) check("unexpected_mac_enable", 1, 0);
        else begin
          logic [15:0] p;
          p = exp_pairs.pop_front();
          check("mac_a", mif.mac_a, p[15:8]);
          check("mac_b", mif.mac_b, p[7:0]);
        end
      end
      if (done) begin
        check("done_one_cycle", prev_done, 0);
        check("busy_at_done", busy, 0);
        if (exp_res.size() == 0) check("unexpected_done", 1, 0);
        else begin
          bit e;
          check("dot_result", dot_result, exp_res.pop_front());
          e = exp_err.pop_front();
`ifdef DVVM_TIMEOUT_EN
          check("err", err, e);
`endif
        end
      end
      prev_done = done;
    end
  end

  task automatic wr(input bit sel, input int addr, input int data);
    wr_sel  = sel;
    wr_addr = addr[ADDR_W-1:0];
    wr_data = data[DATA_W-1:0];
    wr_en   = 1'b1;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic push_pair(input int a, input int b);
    exp_pairs.push_back({a[7:0], b[7:0]});
  endtask

  task automatic start_run(input int n, input logic [ACC_W-1:0] res, input bit e);
    len   = n[ADDR_W:0];
    start = 1'b1;
    exp_res.push_back(res);
    exp_err.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c;
        break;
      end
    end
    if (cyc < 0) check("done_timeout", 0, 1);
    @(posedge clk); #1;
    check("enable_count", exp_pairs.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mac_enable"}, mif.mac_enable, 0);
    check({tag, "_mac_a"}, mif.mac_a, 0);
    check({tag, "_mac_b"}, mif.mac_b, 0);
    check({tag, "_dot_result"}, dot_result, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int cyc;
    bit seen;

    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A=[1,2,3,4], B=[5,6,7,8] -> 5+12+21+32 = 70; write during busy dropped
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, i, i + 1);
      wr(1'b1, i, i + 5);
      push_pair(i + 1, i + 5);
    end
    start_run(4, 70, 1'b0);
    wr(1'b0, 0, 100);
    wait_done(cyc);
    push_pair(1, 5);
    start_run(1, 5, 1'b0);
    wait_done(cyc);

    // Full-depth 255*255*16 = 1040400, then len=17 clamps to 16
    for (int i = 0; i < 16; i++) begin
      wr(1'b0, i, 255);
      wr(1'b1, i, 255);
    end
    for (int i = 0; i < 16; i++) push_pair(255, 255);
    start_run(16, 20'd1040400, 1'b0);
    wait_done(cyc);
    for (int i = 0; i < 16; i++) push_pair(255, 255);
    start_run(17, 20'd1040400, 1'b0);
    wait_done(cyc);

    // len=0: straight to FINISH, done on the second cycle, no issue
    start_run(0, 0, 1'b0);
    wait_done(cyc);
    check("len0_latency", cyc, 1);

    // Level-held MAC done: 3*4 + 15*10 = 162
    mac_mode = 1;
    wr(1'b0, 0, 3);
    wr(1'b0, 1, 15);
    wr(1'b1, 0, 4);
    wr(1'b1, 1, 10);
    push_pair(3, 4);
    push_pair(15, 10);
    start_run(2, 162, 1'b0);
    wait_done(cyc);
    mac_mode = 0;
    @(posedge clk); #1;

    // Abort in WAIT by reset: no done, outputs cleared asynchronously
    wr(1'b0, 0, 7);
    wr(1'b1, 0, 6);
    push_pair(7, 6);
    push_pair(15, 10);
    start_run(2, 0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mif.mac_enable) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_issue_seen", seen, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    exp_pairs.delete();
    exp_res.delete();
    exp_err.delete();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done, 0);
    wr(1'b0, 0, 2);
    wr(1'b1, 0, 9);
    push_pair(2, 9);
    start_run(1, 18, 1'b0);
    wait_done(cyc);

`ifdef DVVM_TIMEOUT_EN
    // Silent MAC: watchdog fires after 64 WAIT cycles with partial acc 0
    mac_mode = 2;
    push_pair(2, 9);
    start_run(1, 0, 1'b1);
    wait_done(cyc);
    check("timeout_latency", cyc, 66);
    mac_mode = 0;
    push_pair(2, 9);
    start_run(1, 18, 1'b0);
    check("err_cleared_on_start", err, 0);
    wait_done(cyc);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
